prbs_checker: RTL and testbench

//  Serial PRBS receiver/checker for the far end of the 1-bit clocked data_path chain.

---
 rtl/prbs_checker.sv | 163 ++++++++++++++++
 tb/tb_prbs_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-syncs a local LFSR to the received stream,
// then flywheels it to count bit errors and checked bits while locked.
module prbs_checker #(
    parameter int TAP_A       = 7,
    parameter int TAP_B       = 6,
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FW = $clog2(TAP_A + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
    localparam int EW = $clog2(LOSS_THRESH + 1);

    localparam logic [FW-1:0]    FILL_FULL  = FW'(TAP_A);
    localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0]    WIN_LAST   = WW'(LOSS_WINDOW - 1);
    localparam logic [EW-1:0]    ERR_LIMIT  = EW'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [TAP_A-1:0]   seed_q, seed_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [MW-1:0]      match_q, match_d;
    logic [WW-1:0]      window_q, window_d;
    logic [EW-1:0]      win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;

    logic               pred;
    logic               mism;
    logic               err_inc;
    logic               bit_inc;
    logic [EW-1:0]      win_sum;

    assign pred = seed_q[TAP_A-1] ^ seed_q[TAP_B-1];
    assign mism = in ^ pred;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        fill_d      = fill_q;
        match_d     = match_q;
        window_d    = window_q;
        win_err_d   = win_err_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        bit_inc     = 1'b0;
        win_sum     = win_err_q + EW'(mism);

        if (en) begin
            unique case (state_q)
                SEARCH: begin
                    seed_d = {seed_q[TAP_A-2:0], in};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + FW'(1);
                    end else if (!mism && seed_q != '0) begin
                        if (match_q >= MATCH_LAST) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            match_d   = '0;
                            window_d  = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a bad bit never poisons the seed.
                    seed_d      = {seed_q[TAP_A-2:0], pred};
                    bit_inc     = 1'b1;
                    err_inc     = mism;
                    err_pulse_d = mism;
                    if (win_sum >= ERR_LIMIT) begin
                        state_d   = SEARCH;
                        locked_d  = 1'b0;
                        fill_d    = '0;
                        match_d   = '0;
                        window_d  = '0;
                        win_err_d = '0;
                    end else if (window_q == WIN_LAST) begin
                        window_d  = '0;
                        win_err_d = '0;
                    end else begin
                        window_d  = window_q + WW'(1);
                        win_err_d = win_sum;
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                end
            endcase
        end

        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        if (clear_cnt) begin
            err_count_d = '0;
            bit_count_d = '0;
        end else begin
            if (err_inc && err_count_q != CNT_MAX)
                err_count_d = err_count_q + CNT_W'(1);
            if (bit_inc && bit_count_q != CNT_MAX)
                bit_count_d = bit_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            seed_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            window_q    <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            window_q    <= window_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: scenario table, hand-built corner sequences,
// and a randomized run against a history-queue reference model.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_bit;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] bit_count;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (in_bit),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    int checks = 0;
    int errors = 0;

    bit p[134];
    int k = 0;

    // Reference model state
    bit          hist[$];
    bit          m_locked;
    bit          m_pulse;
    int          m_fill;
    int          m_match;
    int          m_win;
    int          m_werr;
    logic [31:0] m_err;
    logic [31:0] m_bit;

    typedef struct {
        string name;
        int    kind;
        bit    toggle;
        int    ncyc;
        bit    exp_locked;
        int    exp_err;
        int    exp_bit;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 7; i++) hist.push_back(1'b0);
        m_locked = 0;
        m_pulse  = 0;
        m_fill   = 0;
        m_match  = 0;
        m_win    = 0;
        m_werr   = 0;
        m_err    = 0;
        m_bit    = 0;
    endtask

    task automatic model_step(input bit e, input bit b, input bit c);
        bit pr;
        bit nz;
        m_pulse = 0;
        if (e) begin
            // hist[0] is the bit seen 7 bits ago, hist[1] the one 6 ago
            pr = hist[0] ^ hist[1];
            nz = 0;
            foreach (hist[i]) if (hist[i]) nz = 1;
            void'(hist.pop_front());
            if (!m_locked) begin
                hist.push_back(b);
                if (m_fill < 7) m_fill++;
                else if (b == pr && nz) begin
                    m_match++;
                    if (m_match >= 16) begin
                        m_locked = 1;
                        m_match  = 0;
                        m_win    = 0;
                        m_werr   = 0;
                    end
                end else m_match = 0;
            end else begin
                hist.push_back(pr);
                if (m_bit != 32'hffff_ffff) m_bit++;
                if (b != pr) begin
                    m_pulse = 1;
                    if (m_err != 32'hffff_ffff) m_err++;
                    m_werr++;
                end
                if (m_werr >= 8) begin
                    m_locked = 0;
                    m_fill   = 0;
                    m_match  = 0;
                    m_win    = 0;
                    m_werr   = 0;
                end else begin
                    m_win++;
                    if (m_win == 64) begin
                        m_win  = 0;
                        m_werr = 0;
                    end
                end
            end
        end
        if (c) begin
            m_err = 0;
            m_bit = 0;
        end
    endtask

    task automatic drive(input bit e, input bit b, input bit c);
        en        = e;
        in_bit    = b;
        clear_cnt = c;
        model_step(e, b, c);
        @(posedge clk);
        #1;
    endtask

    task automatic prbs(input bit e, input bit flip, input bit c);
        bit b;
        if (e) begin
            b = p[k % 127] ^ flip;
            k++;
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        drive(e, b, c);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lock_up();
        do_reset();
        repeat (23) prbs(1, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;

        for (int i = 0; i < 7; i++) p[i] = (i == 0);
        for (int i = 7; i < 134; i++) p[i] = p[i-7] ^ p[i-6];

        vecs[0] = '{"clean1000", 2, 1'b0, 1000, 1'b1, 0, 977};
        vecs[1] = '{"zeros200",  0, 1'b0, 200,  1'b0, 0, 0};
        vecs[2] = '{"ones200",   1, 1'b0, 200,  1'b0, 0, 0};
        vecs[3] = '{"prelock22", 2, 1'b0, 22,   1'b0, 0, 0};
        vecs[4] = '{"lock23",    2, 1'b0, 23,   1'b1, 0, 0};
        vecs[5] = '{"toggle_en", 2, 1'b1, 1000, 1'b1, 0, 477};

        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_err", err_count, 0);
        check("rst_bit", bit_count, 0);

        foreach (vecs[v]) begin
            do_reset();
            for (int i = 0; i < vecs[v].ncyc; i++) begin
                bit e;
                e = vecs[v].toggle ? (i % 2 == 0) : 1'b1;
                if (vecs[v].kind == 2) prbs(e, 0, 0);
                else drive(e, vecs[v].kind == 1, 0);
            end
            check({vecs[v].name, "_locked"}, 32'(locked), 32'(vecs[v].exp_locked));
            check({vecs[v].name, "_err"}, err_count, vecs[v].exp_err);
            check({vecs[v].name, "_bit"}, bit_count, vecs[v].exp_bit);
        end

        // Single flipped bit while locked
        lock_up();
        repeat (5) prbs(1, 0, 0);
        prbs(1, 1, 0);
        check("flip_pulse", 32'(err_pulse), 1);
        check("flip_err", err_count, 1);
        check("flip_locked", 32'(locked), 1);
        prbs(1, 0, 0);
        check("flip_pulse_gone", 32'(err_pulse), 0);
        check("flip_no_mult", err_count, 1);
        prbs(0, 0, 0);
        check("en_low_pulse", 32'(err_pulse), 0);

        // Eight errors in one window drop lock, then relock
        lock_up();
        for (int i = 0; i < 8; i++) begin
            prbs(1, 1, 0);
            if (i == 6) check("loss_hold7", 32'(locked), 1);
            if (i < 7) prbs(1, 0, 0);
        end
        check("loss_locked", 32'(locked), 0);
        check("loss_err", err_count, 8);
        check("loss_pulse", 32'(err_pulse), 1);
        check("loss_bit", bit_count, 15);
        repeat (22) prbs(1, 0, 0);
        check("relock22", 32'(locked), 0);
        prbs(1, 0, 0);
        check("relock23", 32'(locked), 1);
        check("relock_err_hold", err_count, 8);

        // clear_cnt behaviour and async reset mid-lock
        lock_up();
        repeat (3) prbs(1, 0, 0);
        drive(0, 0, 1);
        check("clr_en_low", bit_count, 0);
        repeat (3) prbs(1, 0, 0);
        prbs(1, 1, 1);
        check("clr_err", err_count, 0);
        check("clr_bit", bit_count, 0);
        check("clr_pulse", 32'(err_pulse), 1);
        check("clr_locked", 32'(locked), 1);
        prbs(1, 1, 0);
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_pulse", 32'(err_pulse), 0);
        check("arst_err", err_count, 0);
        check("arst_bit", bit_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            bit e;
            bit f;
            bit c;
            e = ($urandom_range(0, 3) != 0);
            f = (i < 2500) ? ($urandom_range(0, 29) == 0)
                           : ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 199) == 0);
            prbs(e, f, c);
            check("rnd_locked", 32'(locked), 32'(m_locked));
            check("rnd_pulse", 32'(err_pulse), 32'(m_pulse));
            check("rnd_err", err_count, m_err);
            check("rnd_bit", bit_count, m_bit);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
